// File: rtl/shift_pkg.sv
// Shared types and default sizing for the load-and-shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 4;

endpackage

// File: rtl/shift_dp.sv
// Shift datapath: loadable left-shift register, remaining-shift down-counter
// and the registered bit shifted out of the MSB.
module shift_dp
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] cnt_init,
    output logic [WIDTH-1:0] data,
    output logic             cnt_last,
    output logic             msb,
    output logic             msb_vld
);

    logic [AMT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data    <= '0;
            cnt     <= '0;
            msb     <= 1'b0;
            msb_vld <= 1'b0;
        end else begin
            // Valid only follows a real shift, so an aborted cycle drops it.
            msb_vld <= shift_en;
            if (load) begin
                data <= din;
                cnt  <= cnt_init;
            end else if (shift_en) begin
                data <= {data[WIDTH-2:0], 1'b0};
                msb  <= data[WIDTH-1];
                cnt  <= cnt - 1'b1;
            end
        end
    end

    assign cnt_last = (cnt == AMT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load-and-shift sequencer: accepts a value and a shift amount, shifts left
// one bit per cycle, then pulses done. Abort cancels without a done pulse.
//
//   state | meaning
//   IDLE  | ready for start; abort ignored
//   SHIFT | one left shift per cycle until the count reaches its last step
//   DONE  | one-cycle done pulse, result held, always returns to IDLE
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             sout_vld
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    state_t           state;
    logic             load;
    logic             shift_en;
    logic             cnt_last;
    logic [AMT_W-1:0] amt_clamped;

    // Shifting more than WIDTH times only produces zeros, so stop at WIDTH.
    assign amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign load        = (state == IDLE) && start;
    assign shift_en    = (state == SHIFT) && !abort;

    shift_dp #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) u_dp (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .shift_en(shift_en),
        .din     (din),
        .cnt_init(amt_clamped),
        .data    (dout),
        .cnt_last(cnt_last),
        .msb     (sout),
        .msb_vld (sout_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (amt_clamped != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (cnt_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases then random
// operations, compared against per-cycle expectations computed arithmetically.
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [W-1:0]  din;
    logic [AW-1:0] amt;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  dout;
    logic          sout;
    logic          sout_vld;

    int total = 0;
    int bad   = 0;
    logic m_sout = 1'b0;

    shift_seq_ctrl #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .abort   (abort),
        .din     (din),
        .amt     (amt),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .sout    (sout),
        .sout_vld(sout_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_dout, input logic e_sout,
                           input logic e_vld, input logic e_busy, input logic e_done,
                           input logic e_ready);
        chk({tag, ".dout"},     32'(dout),     32'(e_dout));
        chk({tag, ".sout"},     32'(sout),     32'(e_sout));
        chk({tag, ".sout_vld"}, 32'(sout_vld), 32'(e_vld));
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".done"},     32'(done),     32'(e_done));
        chk({tag, ".ready"},    32'(ready),    32'(e_ready));
    endtask

    // Called #1 after an edge with the DUT idle. Sample j is taken #1 after
    // the j-th edge following the start edge.
    task automatic op(input string name, input logic [W-1:0] d, input int a,
                      input int abort_after, input int restart_at, input int rst_after,
                      input bit abort_with_start, input bit abort_in_done);
        int          n;
        int          sh;
        bit          fin;
        logic [15:0] wide;
        string       tag;
        n     = (a > W) ? W : a;
        din   = d;
        amt   = AW'(a);
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        din   = W'($urandom);
        fin   = 1'b0;
        for (int j = 0; !fin; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                abort = 1'b0;
            end
            tag = $sformatf("%s.s%0d", name, j);
            if (abort_after >= 0 && j == abort_after + 1) begin
                wide = {8'h00, d} << abort_after;
                chk_all({tag, ".abort"}, wide[7:0], m_sout, 1'b0, 1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1;
                chk_all({tag, ".post_abort"}, wide[7:0], m_sout, 1'b0, 1'b0, 1'b0, 1'b1);
                fin = 1'b1;
            end else begin
                sh   = (j < n) ? j : n;
                wide = {8'h00, d} << sh;
                if (j >= 1 && j <= n) m_sout = d[W-j];
                chk_all(tag, wide[7:0], m_sout, (j >= 1 && j <= n), (j < n), (j == n),
                        (j == n + 1));
                if (j == n + 1) fin = 1'b1;
            end
            if (!fin) begin
                if (abort_after == j) abort = 1'b1;
                if (abort_in_done && j == n && abort_after < 0) abort = 1'b1;
                if (restart_at == j) begin
                    start = 1'b1;
                    din   = W'($urandom);
                    amt   = AW'($urandom);
                end
                if (rst_after == j) begin
                    #2;
                    rstn = 1'b0;
                    #1;
                    m_sout = 1'b0;
                    chk_all({tag, ".rst"}, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    start = 1'b0;
                    abort = 1'b0;
                    @(posedge clk);
                    #1;
                    chk_all({tag, ".rst_hold"}, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    rstn = 1'b1;
                    fin  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int a;
        int n;
        int ab;
        int rs;
        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        din   = '0;
        amt   = '0;
        #12;
        chk_all("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        op("d55_a1",  8'h55, 1,  -1, -1, -1, 1'b0, 1'b0);
        op("dA5_a0",  8'hA5, 0,  -1, -1, -1, 1'b0, 1'b0);
        op("d55_a8",  8'h55, 8,  -1, -1, -1, 1'b0, 1'b0);
        op("d55_a12", 8'h55, 12, -1, -1, -1, 1'b0, 1'b0);
        op("dFF_rst", 8'hFF, 4,  -1, 1,  -1, 1'b0, 1'b0);
        op("d81_abt", 8'h81, 6,  2,  -1, -1, 1'b0, 1'b0);
        op("d3C_rst", 8'h3C, 5,  -1, -1, 3,  1'b0, 1'b0);
        op("after_rst", 8'h96, 3, -1, -1, -1, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a  = int'($urandom_range(0, 15));
            n  = (a > W) ? W : a;
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
            op($sformatf("rnd%0d", i), W'($urandom), a, ab, rs, -1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
